pg_domain_scheduler: RTL and testbench
======================================

Name: pg_domain_scheduler

Overview:
- Policy scheduler above the per-domain power-gate controllers.
- Watches per-domain activity and pending work, then decides which domains sleep or wake.
- Issues sleep/wake requests one domain at a time, which bounds inrush current and rail disturbance.
- Round-robin among candidates; wakes always outrank sleeps.

Parameters:
NUM_DOM, 4, number of gated domains (2..16)
IDLE_CYCLES, 256, consecutive idle cycles before a domain becomes a sleep candidate (>=1)
ACK_TIMEOUT, 16, cycles allowed for a controller's ready to fall after a request (>=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = gating allowed; 0 = issue no sleeps and wake every off domain
dom_busy  input  NUM_DOM  domain currently executing work
dom_wake_need  input  NUM_DOM  work pending for domain (scheduler queue non-empty)
pg_ready  input  NUM_DOM  per-controller ready: high when stable on/off, low while transitioning
sleep_req  output  NUM_DOM  per-controller sleep request, level, held until ready falls
wake_req  output  NUM_DOM  per-controller wake request, level, held until ready falls
dom_on  output  NUM_DOM  1 = domain powered and usable
seq_busy  output  1  a transition is in flight
err_timeout  output  NUM_DOM  sticky: controller failed to acknowledge; domain is excluded thereafter

Behaviour:
- Reset (async): state=ARB, dom_on=all 1, sleep_req=0, wake_req=0, seq_busy=0, err_timeout=0, idle counters=0, rr_ptr=0, timeout counter=0.
- Idle counter per domain, width clog2(IDLE_CYCLES+1):
  - Increments while dom_on & ~dom_busy & ~dom_wake_need.
  - Clears when busy or wake_need is asserted, or when the domain completes a transition.
  - Saturates at IDLE_CYCLES.
- Candidates, excluding domains with err_timeout set:
  - wake_cand = ~dom_on & (dom_wake_need | ~en)
  - sleep_cand = dom_on & en & (idle_cnt==IDLE_CYCLES) & ~dom_busy & ~dom_wake_need
- FSM states: ARB, REQ, WAIT_DONE.
- ARB:
  - If wake_cand!=0, grant the first wake_cand at or after rr_ptr (cyclic).
  - Otherwise grant the first sleep_cand at or after rr_ptr.
  - On grant: latch index g and direction; assert the matching req[g] (registered, visible next cycle); seq_busy=1; rr_ptr=g+1 mod NUM_DOM; timeout counter=0; go REQ.
  - No candidate: remain in ARB with seq_busy=0.
- REQ:
  - If pg_ready[g]==0: deassert req, go WAIT_DONE.
  - Else increment the counter.
  - When the counter reaches ACK_TIMEOUT-1 with ready still high: deassert req, set err_timeout[g], leave dom_on[g] unchanged, seq_busy=0, go ARB.
- WAIT_DONE:
  - Wait with no timeout until pg_ready[g]==1.
  - Then set dom_on[g]=1 for a wake or 0 for a sleep, clear idle_cnt[g], seq_busy=0, go ARB.
  - Minimum spacing between consecutive grants is therefore one ARB cycle.
- Only one req bit is ever high across both vectors; sleep_req and wake_req are never high together.
- Domain becomes busy or needs work while its sleep is in flight: the sleep completes, dom_on falls, and the domain becomes a wake candidate in the next ARB cycle.
- Simultaneous wake and sleep candidates: the wake wins even if the sleep domain is nearer to rr_ptr.
- en falling mid-sequence: the current transition completes; after that, no sleeps are issued and off domains are woken in round-robin order.
- dom_busy asserted on an off domain is ignored. Only wake_need or ~en triggers a wake.
- Reset mid-sequence: all outputs return to reset values immediately, and dom_on reads all 1. The controllers reset alongside on the shared rst_n.

Test Plan (NUM_DOM=4, IDLE_CYCLES=16, ACK_TIMEOUT=8; model controllers: ready falls 1 cycle after req, rises 20 cycles later):
- All domains idle, en=1 -> sleeps for d0,d1,d2,d3 in order, each starting only after the prior ready rose; final dom_on=4'b0000; each req held exactly 2 cycles.
- All off, dom_wake_need=4'b1010 -> wake d1, then d3; dom_on=4'b1010; d0 and d2 stay off.
- d2 sleeping in flight when dom_wake_need[2]=1 -> sleep completes with dom_on[2]=0, then the next grant is wake d2 ahead of a pending sleep candidate d3.
- Controller d1 model never drops ready on sleep_req -> req held 8 cycles, err_timeout=4'b0010, dom_on[1] stays 1, d1 never requested again, arbitration continues with d2.
- All off, en dropped to 0 -> all four woken in rr order; no sleep issued while en=0 even with idle counters saturated.
- Assert rst_n low during WAIT_DONE -> same cycle: req=0, seq_busy=0, dom_on=4'b1111, err_timeout=0.

Source files
------------

// File: rtl/pg_domain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pg_domain_scheduler
// Description : Policy scheduler sitting above the per-domain power-gate
//               controllers. Tracks per-domain idleness and pending work,
//               then issues sleep/wake requests one domain at a time so that
//               only a single rail is ever switching (bounded inrush).
//               Round-robin among candidates; wakes always outrank sleeps.
//
// Ports       : clk            - clock
//               rst_n          - asynchronous active-low reset
//               en             - 1: gating allowed; 0: no sleeps, wake all off
//               dom_busy       - per-domain: currently executing work
//               dom_wake_need  - per-domain: work pending for the domain
//               pg_ready       - per-controller: stable on/off (low = moving)
//               sleep_req      - per-controller sleep request (level)
//               wake_req       - per-controller wake request (level)
//               dom_on         - per-domain: powered and usable
//               seq_busy       - a transition is in flight
//               err_timeout    - sticky per-domain acknowledge failure
//
// Revision    : 1.0 - initial release
// ============================================================================
module pg_domain_scheduler #(
  parameter int NUM_DOM     = 4,
  parameter int IDLE_CYCLES = 256,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_DOM-1:0] dom_busy,
  input  logic [NUM_DOM-1:0] dom_wake_need,
  input  logic [NUM_DOM-1:0] pg_ready,
  output logic [NUM_DOM-1:0] sleep_req,
  output logic [NUM_DOM-1:0] wake_req,
  output logic [NUM_DOM-1:0] dom_on,
  output logic               seq_busy,
  output logic [NUM_DOM-1:0] err_timeout
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int c_IDX_W = $clog2(NUM_DOM);
  localparam int c_CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam int c_TMO_W = $clog2(ACK_TIMEOUT);

  localparam logic [c_CNT_W-1:0] c_IDLE_MAX = c_CNT_W'(IDLE_CYCLES);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DOM - 1);
  localparam logic [c_IDX_W:0]   c_NUM_DOM  = (c_IDX_W + 1)'(NUM_DOM);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                          r_state;
  logic [c_IDX_W-1:0]              r_sel;        // domain being transitioned
  logic                            r_dir_wake;   // 1 = wake, 0 = sleep
  logic [c_IDX_W-1:0]              r_rr_ptr;
  logic [c_TMO_W-1:0]              r_tmo_cnt;
  logic [NUM_DOM-1:0]              r_sleep_req;
  logic [NUM_DOM-1:0]              r_wake_req;
  logic [NUM_DOM-1:0]              r_dom_on;
  logic                            r_seq_busy;
  logic [NUM_DOM-1:0]              r_err;
  logic [NUM_DOM-1:0][c_CNT_W-1:0] r_idle_cnt;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [NUM_DOM-1:0] w_done;        // domain finishing its transition now
  logic [NUM_DOM-1:0] w_wake_cand;
  logic [NUM_DOM-1:0] w_sleep_cand;
  logic               w_wake_hit;
  logic [c_IDX_W-1:0] w_wake_idx;
  logic               w_sleep_hit;
  logic [c_IDX_W-1:0] w_sleep_idx;
  logic               w_grant;
  logic               w_grant_wake;
  logic [c_IDX_W-1:0] w_grant_idx;
  logic [c_IDX_W-1:0] w_rr_next;

  assign sleep_req   = r_sleep_req;
  assign wake_req    = r_wake_req;
  assign dom_on      = r_dom_on;
  assign seq_busy    = r_seq_busy;
  assign err_timeout = r_err;

  // A transition completes in WAIT_DONE on the first cycle the selected
  // controller reports ready again.
  always_comb begin
    w_done = '0;
    if (r_state == WAIT_DONE && pg_ready[r_sel]) begin
      w_done[r_sel] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Idle counters: count consecutive idle cycles of powered domains,
  // saturating at IDLE_CYCLES. Any activity or a finished transition restarts
  // the count, so a freshly woken domain must idle the full window again.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_DOM; i++) begin
        if (w_done[i] || dom_busy[i] || dom_wake_need[i]) begin
          r_idle_cnt[i] <= '0;
        end else if (r_dom_on[i] && (r_idle_cnt[i] != c_IDLE_MAX)) begin
          r_idle_cnt[i] <= r_idle_cnt[i] + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Candidate vectors. Domains whose controller has timed out are excluded
  // permanently (until reset). dom_busy alone never wakes an off domain.
  // --------------------------------------------------------------------------
  assign w_wake_cand = ~r_dom_on & (dom_wake_need | {NUM_DOM{~en}}) & ~r_err;

  for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_sleep_cand
    assign w_sleep_cand[gi] = r_dom_on[gi] & en
                            & (r_idle_cnt[gi] == c_IDLE_MAX)
                            & ~dom_busy[gi] & ~dom_wake_need[gi] & ~r_err[gi];
  end

  // --------------------------------------------------------------------------
  // Round-robin pickers: first candidate at or after r_rr_ptr, cyclic.
  // Scanning from the farthest offset down to zero lets the nearest hit
  // overwrite any farther one.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [c_IDX_W:0]   v_sum;
    logic [c_IDX_W-1:0] v_idx;
    w_wake_hit  = 1'b0;
    w_wake_idx  = '0;
    w_sleep_hit = 1'b0;
    w_sleep_idx = '0;
    v_sum       = '0;
    v_idx       = '0;
    for (int k = NUM_DOM - 1; k >= 0; k--) begin
      v_sum = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(k);
      if (v_sum >= c_NUM_DOM) begin
        v_sum = v_sum - c_NUM_DOM;
      end
      v_idx = v_sum[c_IDX_W-1:0];
      if (w_wake_cand[v_idx]) begin
        w_wake_hit = 1'b1;
        w_wake_idx = v_idx;
      end
      if (w_sleep_cand[v_idx]) begin
        w_sleep_hit = 1'b1;
        w_sleep_idx = v_idx;
      end
    end
  end

  // Wakes always win, regardless of where the sleep candidate sits.
  assign w_grant      = w_wake_hit | w_sleep_hit;
  assign w_grant_wake = w_wake_hit;
  assign w_grant_idx  = w_wake_hit ? w_wake_idx : w_sleep_idx;
  assign w_rr_next    = (w_grant_idx == c_IDX_LAST) ? '0 : w_grant_idx + 1'b1;

  // --------------------------------------------------------------------------
  // Sequencer FSM: one transition at a time.
  //   ARB       - pick a domain and raise its request
  //   REQ       - hold the request until the controller drops ready, or give
  //               up after ACK_TIMEOUT cycles and mark the domain faulty
  //   WAIT_DONE - wait (unbounded) for ready to return, then commit dom_on
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB;
      r_sel       <= '0;
      r_dir_wake  <= 1'b0;
      r_rr_ptr    <= '0;
      r_tmo_cnt   <= '0;
      r_sleep_req <= '0;
      r_wake_req  <= '0;
      r_dom_on    <= '1;
      r_seq_busy  <= 1'b0;
      r_err       <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_grant) begin
            r_sel      <= w_grant_idx;
            r_dir_wake <= w_grant_wake;
            if (w_grant_wake) begin
              r_wake_req[w_grant_idx] <= 1'b1;
            end else begin
              r_sleep_req[w_grant_idx] <= 1'b1;
            end
            r_seq_busy <= 1'b1;
            r_rr_ptr   <= w_rr_next;
            r_tmo_cnt  <= '0;
            r_state    <= REQ;
          end
        end

        REQ: begin
          if (!pg_ready[r_sel]) begin
            // Controller has accepted; the request has done its job.
            r_sleep_req <= '0;
            r_wake_req  <= '0;
            r_state     <= WAIT_DONE;
          end else if (r_tmo_cnt == c_TMO_LAST) begin
            // No acknowledge: drop the request, leave dom_on as it was and
            // fence the domain off from further arbitration.
            r_sleep_req  <= '0;
            r_wake_req   <= '0;
            r_err[r_sel] <= 1'b1;
            r_seq_busy   <= 1'b0;
            r_state      <= ARB;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (pg_ready[r_sel]) begin
            r_dom_on[r_sel] <= r_dir_wake;
            r_seq_busy      <= 1'b0;
            r_state         <= ARB;
          end
        end

        default: begin
          r_sleep_req <= '0;
          r_wake_req  <= '0;
          r_seq_busy  <= 1'b0;
          r_state     <= ARB;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pg_domain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pg_domain_scheduler
// Description : Self-checking bench for pg_domain_scheduler. Model power-gate
//               controllers answer the requests; a transaction-level reference
//               model predicts grants (pushed to a queue) and outputs; a
//               negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pg_domain_scheduler;

  localparam int N    = 4;
  localparam int IDLE = 16;
  localparam int ACK  = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] dom_busy;
  logic [N-1:0] dom_wake_need;
  logic [N-1:0] pg_ready;
  logic [N-1:0] sleep_req;
  logic [N-1:0] wake_req;
  logic [N-1:0] dom_on;
  logic         seq_busy;
  logic [N-1:0] err_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pg_domain_scheduler #(
    .NUM_DOM    (N),
    .IDLE_CYCLES(IDLE),
    .ACK_TIMEOUT(ACK)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .dom_busy     (dom_busy),
    .dom_wake_need(dom_wake_need),
    .pg_ready     (pg_ready),
    .sleep_req    (sleep_req),
    .wake_req     (wake_req),
    .dom_on       (dom_on),
    .seq_busy     (seq_busy),
    .err_timeout  (err_timeout)
  );

  // --------------------------------------------------------------------------
  // Controller models: ready falls one cycle after a request is seen, stays
  // low for a random 2..20 cycles, then rises. A "dead" controller ignores
  // requests entirely.
  // --------------------------------------------------------------------------
  logic [N-1:0] dead;
  int           ctl_cnt[N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_ready <= '1;
      for (int i = 0; i < N; i++) ctl_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ctl_cnt[i] > 0) begin
          ctl_cnt[i] <= ctl_cnt[i] - 1;
          if (ctl_cnt[i] == 1) pg_ready[i] <= 1'b1;
        end else if ((sleep_req[i] | wake_req[i]) && pg_ready[i] && !dead[i]) begin
          pg_ready[i] <= 1'b0;
          ctl_cnt[i]  <= $urandom_range(20, 2);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: one transaction at a time. While idle it applies the
  // candidate rules to decide the next grant; while a transaction is open it
  // follows the selected controller's ready to decide when it ends.
  // --------------------------------------------------------------------------
  typedef struct {
    int cyc;
    int g;
    bit wake;
  } grant_t;

  grant_t       exp_q[$];
  logic [N-1:0] m_on;
  logic [N-1:0] m_err;
  int           m_idle[N];
  int           m_rr;
  bit           m_act;    // transaction open
  bit           m_low;    // controller acknowledged (ready seen low)
  bit           m_req;    // request line expected high
  bit           m_wake;
  int           m_g;
  int           m_age;
  int           m_cyc = 0;

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      m_on  <= '1;
      m_err <= '0;
      m_rr  <= 0;
      m_act <= 1'b0;
      m_low <= 1'b0;
      m_req <= 1'b0;
      m_wake <= 1'b0;
      m_g   <= 0;
      m_age <= 0;
      for (int i = 0; i < N; i++) m_idle[i] <= 0;
      exp_q.delete();
    end else begin : step
      logic [N-1:0] n_on, n_err, wset, sset;
      int           n_idle[N];
      bit           n_act, n_low, n_req, n_wake;
      int           n_g, n_age, n_rr, pick;
      grant_t       e;
      n_on = m_on; n_err = m_err; n_act = m_act; n_low = m_low;
      n_req = m_req; n_wake = m_wake; n_g = m_g; n_age = m_age; n_rr = m_rr;
      pick = -1;
      for (int i = 0; i < N; i++) begin
        if (dom_busy[i] || dom_wake_need[i]) n_idle[i] = 0;
        else if (m_on[i] && m_idle[i] < IDLE) n_idle[i] = m_idle[i] + 1;
        else n_idle[i] = m_idle[i];
      end
      if (m_act) begin
        if (!m_low) begin
          if (!pg_ready[m_g]) begin
            n_low = 1'b1;
            n_req = 1'b0;
          end else if (m_age + 1 >= ACK) begin
            n_req = 1'b0;
            n_err[m_g] = 1'b1;
            n_act = 1'b0;
          end else begin
            n_age = m_age + 1;
          end
        end else if (pg_ready[m_g]) begin
          n_on[m_g]   = m_wake;
          n_idle[m_g] = 0;
          n_act = 1'b0;
          n_low = 1'b0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          wset[i] = !m_on[i] && (dom_wake_need[i] || !en) && !m_err[i];
          sset[i] = m_on[i] && en && (m_idle[i] == IDLE) && !dom_busy[i]
                    && !dom_wake_need[i] && !m_err[i];
        end
        for (int k = 0; k < N; k++) begin
          int d;
          d = (m_rr + k) % N;
          if (pick < 0 && wset[d]) begin pick = d; n_wake = 1'b1; end
        end
        if (pick < 0) begin
          for (int k = 0; k < N; k++) begin
            int d;
            d = (m_rr + k) % N;
            if (pick < 0 && sset[d]) begin pick = d; n_wake = 1'b0; end
          end
        end
        if (pick >= 0) begin
          n_act = 1'b1; n_low = 1'b0; n_req = 1'b1; n_age = 0;
          n_g = pick;
          n_rr = (pick + 1) % N;
          e.cyc = m_cyc + 1; e.g = pick; e.wake = n_wake;
          exp_q.push_back(e);
        end
      end
      m_on <= n_on; m_err <= n_err; m_act <= n_act; m_low <= n_low;
      m_req <= n_req; m_wake <= n_wake; m_g <= n_g; m_age <= n_age; m_rr <= n_rr;
      for (int i = 0; i < N; i++) m_idle[i] <= n_idle[i];
    end
  end

  always @(posedge clk) m_cyc <= m_cyc + 1;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, m_cyc);
    end
  endtask

  logic [N-1:0] prev_req;

  always @(negedge clk) begin : monitor
    logic [N-1:0] es, ew, rise;
    grant_t       e;
    if (!rst_n) begin
      prev_req = '0;
    end else begin
      es = '0; ew = '0;
      if (m_req) begin
        if (m_wake) ew[m_g] = 1'b1;
        else        es[m_g] = 1'b1;
      end
      chk("sleep_req", 32'(sleep_req), 32'(es));
      chk("wake_req", 32'(wake_req), 32'(ew));
      chk("dom_on", 32'(dom_on), 32'(m_on));
      chk("err_timeout", 32'(err_timeout), 32'(m_err));
      chk("seq_busy", 32'(seq_busy), 32'(m_act));
      rise = (sleep_req | wake_req) & ~prev_req;
      if (rise != '0) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_unexpected: got sleep=%b wake=%b, want no grant (cycle %0d)",
                   sleep_req, wake_req, m_cyc);
        end else begin
          e = exp_q.pop_front();
          es = '0; ew = '0;
          if (e.wake) ew[e.g] = 1'b1;
          else        es[e.g] = 1'b1;
          chk("grant", {20'(m_cyc), 4'(sleep_req), 4'(wake_req)},
              {20'(e.cyc), 4'(es), 4'(ew)});
        end
      end
      prev_req = sleep_req | wake_req;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic random_phase(input int iters);
    for (int it = 0; it < iters; it++) begin
      if ($urandom_range(3, 0) == 0) begin
        dom_busy      = '0;
        dom_wake_need = '0;
      end else begin
        dom_busy      = N'($urandom & $urandom & $urandom);
        dom_wake_need = N'($urandom & $urandom);
      end
      en = ($urandom_range(7, 0) != 0);
      cycles($urandom_range(12, 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; dom_busy = '0; dom_wake_need = '0; dead = '0;
    cycles(3);
    chk("reset_dom_on", 32'(dom_on), 32'hF);
    chk("reset_req", 32'(sleep_req | wake_req), 32'h0);
    chk("reset_seq_busy", 32'(seq_busy), 32'h0);
    chk("reset_err", 32'(err_timeout), 32'h0);
    rst_n = 1'b1;

    // All idle with gating allowed: every domain sleeps in rr order.
    cycles(300);
    chk("all_sleep_dom_on", 32'(dom_on), 32'h0);

    // Work pending for d1 and d3 only.
    dom_wake_need = 4'b1010;
    cycles(150);
    chk("wake_1010_dom_on", 32'(dom_on), 32'hA);

    // d1's controller dies; d1 and d3 go idle and are put to sleep.
    dead = 4'b0010;
    dom_wake_need = '0;
    cycles(200);
    chk("timeout_err", 32'(err_timeout), 32'h2);
    chk("timeout_dom_on", 32'(dom_on), 32'h2);

    // Gating disabled: every off domain wakes, no sleeps while idle.
    en = 1'b0;
    cycles(150);
    chk("en0_dom_on", 32'(dom_on), 32'hF);
    chk("en0_idle_seq_busy", 32'(seq_busy), 32'h0);

    dead = '0;
    random_phase(300);

    // Reset while a transition waits for its controller to finish.
    en = 1'b1; dom_busy = '0;
    begin
      int c;
      for (c = 0; c < 2000 && !(m_act && m_low); c++) begin
        if (c % 10 == 0) dom_wake_need = N'($urandom & $urandom);
        @(negedge clk);
      end
      if (!(m_act && m_low)) begin
        total++; bad++;
        $display("FAIL wait_done_reach: got no transition in 2000 cycles, want one");
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_req", 32'(sleep_req | wake_req), 32'h0);
    chk("midreset_seq_busy", 32'(seq_busy), 32'h0);
    chk("midreset_dom_on", 32'(dom_on), 32'hF);
    chk("midreset_err", 32'(err_timeout), 32'h0);
    cycles(3);
    rst_n = 1'b1;

    dead = 4'b1000;
    random_phase(150);
    dead = '0;
    random_phase(150);

    en = 1'b1; dom_busy = '0; dom_wake_need = '0;
    cycles(60);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
